// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
// lamp_pkg: shared lamp colour codes, phase encodings and phase helpers.
// Revision: 1.0
// ============================================================================
package lamp_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    typedef enum logic [1:0] {
        PH_UNSYNC = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    // Any non-one-hot code, including all-dark, maps to PH_UNSYNC.
    function automatic phase_t code_to_phase(input logic [2:0] code);
        case (code)
            RED:     return PH_RED;
            GREEN:   return PH_GREEN;
            YELLOW:  return PH_YELLOW;
            default: return PH_UNSYNC;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_UNSYNC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_hold_timer.sv
`default_nettype none
// ============================================================================
// lamp_hold_timer: saturating run-length counter, pulses stuck when the run reaches MAX_HOLD.
// Revision: 1.0
// ============================================================================
module lamp_hold_timer #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    input  logic hold,
    output logic stuck
);

    localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt;

    // Neither restart nor hold means the bus left the legal set: run length drops to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (restart) begin
            hold_cnt <= HOLD_W'(1);
        end else if (hold) begin
            if (hold_cnt != MAX_CNT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else begin
            hold_cnt <= '0;
        end
    end

    assign stuck = hold && (hold_cnt == MAX_CNT - 1'b1);

endmodule
`default_nettype wire

// File: rtl/lamp_seq_monitor.sv
`default_nettype none
// ============================================================================
// lamp_seq_monitor: RGY lamp bus checker; LAMP_SEQ_MONITOR_HOLD_CHECK_EN enables stuck detection.
// Revision: 1.0
// ============================================================================
module lamp_seq_monitor
    import lamp_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [0:2]       light,
    input  logic             clear_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             code_err,
    output logic             order_err,
    output logic             stuck_err,
    output logic             err_any
);

    phase_t state;
    phase_t obs;
    logic   legal;
    logic   same;
    logic   adv;
    logic   order_hit;
    logic   stuck_pulse;

    assign obs       = code_to_phase(light);
    assign legal     = (obs != PH_UNSYNC);
    assign same      = legal && (obs == state);
    assign adv       = (state != PH_UNSYNC) && (obs == next_phase(state));
    assign order_hit = legal && (state != PH_UNSYNC) && !same && !adv;

`ifdef LAMP_SEQ_MONITOR_HOLD_CHECK_EN
    logic restart;
    assign restart = legal && !same;

    lamp_hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_hold_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (restart),
        .hold    (same),
        .stuck   (stuck_pulse)
    );
`else
    logic unused_hold_params;
    assign unused_hold_params = ^{MAX_HOLD[0], HOLD_W[0]};
    assign stuck_pulse        = 1'b0;
`endif

    // Every outcome (stay, advance, resync, drop to UNSYNC) ends in the observed phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PH_UNSYNC;
            locked    <= 1'b0;
            cycle_cnt <= '0;
            code_err  <= 1'b0;
            order_err <= 1'b0;
            stuck_err <= 1'b0;
        end else begin
            state  <= obs;
            locked <= legal;
            if (adv && (state == PH_YELLOW)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            code_err  <= (code_err  & ~clear_err) | ~legal;
            order_err <= (order_err & ~clear_err) | order_hit;
            stuck_err <= (stuck_err & ~clear_err) | stuck_pulse;
        end
    end

    assign phase   = state;
    assign err_any = code_err | order_err | stuck_err;

endmodule
`default_nettype wire

// File: tb/tb_lamp_seq_monitor.sv
`default_nettype none
// ============================================================================
// tb_lamp_seq_monitor: directed scenarios plus random traffic against a phase-rule model.
// Revision: 1.0
// ============================================================================
module tb_lamp_seq_monitor;

    localparam int CNT_W    = 3;
    localparam int MAX_HOLD = 8;
    localparam int HOLD_W   = 4;
    localparam int VW       = CNT_W + 7;

`ifdef LAMP_SEQ_MONITOR_HOLD_CHECK_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam logic [2:0] C_R = 3'b100;
    localparam logic [2:0] C_G = 3'b010;
    localparam logic [2:0] C_Y = 3'b001;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic [0:2]       light     = 3'b000;
    logic             clear_err = 1'b0;
    logic [1:0]       phase;
    logic             locked;
    logic [CNT_W-1:0] cycle_cnt;
    logic             code_err;
    logic             order_err;
    logic             stuck_err;
    logic             err_any;
    logic [VW-1:0]    dut_vec;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_hold;
    int m_cyc;
    bit m_code;
    bit m_ord;
    bit m_stuck;

    lamp_seq_monitor #(
        .CNT_W    (CNT_W),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .light     (light),
        .clear_err (clear_err),
        .phase     (phase),
        .locked    (locked),
        .cycle_cnt (cycle_cnt),
        .code_err  (code_err),
        .order_err (order_err),
        .stuck_err (stuck_err),
        .err_any   (err_any)
    );

    always #5 clock = ~clock;

    assign dut_vec = {phase, locked, cycle_cnt, code_err, order_err, stuck_err, err_any};

    // Colour index 1..3 for R/G/Y, 0 for anything not one-hot.
    function automatic int colour(input logic [2:0] c);
        if (c == C_R) return 1;
        if (c == C_G) return 2;
        if (c == C_Y) return 3;
        return 0;
    endfunction

    function automatic logic [2:0] code_of(input int idx);
        logic [2:0] base;
        base = 3'b100;
        return base >> (idx - 1);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {2'(m_phase), (m_phase != 0), CNT_W'(m_cyc), m_code, m_ord, m_stuck,
                (m_code | m_ord | m_stuck)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_hold = 0; m_cyc = 0;
        m_code = 0; m_ord = 0; m_stuck = 0;
    endtask

    task automatic model_step(input logic [2:0] l, input bit clr);
        int c;
        bit nc, no, ns;
        c = colour(l);
        nc = 0; no = 0; ns = 0;
        if (c == 0) begin
            nc = 1; m_phase = 0; m_hold = 0;
        end else if (m_phase == 0) begin
            m_phase = c; m_hold = 1;
        end else if (c == m_phase) begin
            if (m_hold < MAX_HOLD) begin
                m_hold++;
                if (m_hold == MAX_HOLD && HOLD_EN) ns = 1;
            end
        end else if (c == (m_phase % 3) + 1) begin
            if (m_phase == 3) m_cyc = (m_cyc + 1) % (1 << CNT_W);
            m_phase = c; m_hold = 1;
        end else begin
            no = 1; m_phase = c; m_hold = 1;
        end
        m_code  = (clr ? 1'b0 : m_code)  | nc;
        m_ord   = (clr ? 1'b0 : m_ord)   | no;
        m_stuck = (clr ? 1'b0 : m_stuck) | ns;
    endtask

    task automatic drive(input logic [2:0] l, input bit clr);
        light = l;
        clear_err = clr;
        @(posedge clock);
        model_step(l, clr);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", dut_vec, {VW{1'b0}}); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        reset_n = 1'b1;
    endtask

    task automatic test_cycles();
        logic [2:0] seq [3];
        seq = '{C_R, C_G, C_Y};
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 3; k++) begin
                drive(seq[k], 1'b0);
                checks++; if (phase !== 2'(k + 1) || locked !== 1'b1 || err_any !== 1'b0) begin errors++; $display("FAIL cycle_step: got phase=%0d locked=%b err=%b expected phase=%0d locked=1 err=0", phase, locked, err_any, k + 1); end
                checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL cycle_model: got %b expected %b", dut_vec, exp_vec()); end
            end
        end
        drive(C_R, 1'b0);
        checks++; if (cycle_cnt !== 3'd4) begin errors++; $display("FAIL cycle_count: got %0d expected 4", cycle_cnt); end
    endtask

    task automatic test_order();
        drive(C_G, 1'b0);
        drive(C_R, 1'b0);
        checks++; if (order_err !== 1'b1 || phase !== 2'd1 || cycle_cnt !== 3'd4) begin errors++; $display("FAIL order_set: got ord=%b phase=%0d cnt=%0d expected ord=1 phase=1 cnt=4", order_err, phase, cycle_cnt); end
        drive(C_G, 1'b1);
        checks++; if (order_err !== 1'b0 || err_any !== 1'b0) begin errors++; $display("FAIL order_clear: got ord=%b any=%b expected 0 0", order_err, err_any); end
    endtask

    task automatic test_code();
        drive(3'b110, 1'b0);
        checks++; if (code_err !== 1'b1 || phase !== 2'd0 || locked !== 1'b0) begin errors++; $display("FAIL code_110: got code=%b phase=%0d locked=%b expected 1 0 0", code_err, phase, locked); end
        drive(3'b000, 1'b0);
        checks++; if (dut_vec !== exp_vec() || code_err !== 1'b1) begin errors++; $display("FAIL code_000: got %b expected %b", dut_vec, exp_vec()); end
        drive(C_Y, 1'b0);
        checks++; if (phase !== 2'd3 || order_err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL code_relock: got phase=%0d ord=%b locked=%b expected 3 0 1", phase, order_err, locked); end
        drive(C_R, 1'b1);
        checks++; if (dut_vec !== exp_vec() || err_any !== 1'b0) begin errors++; $display("FAIL code_clear: got %b expected %b", dut_vec, exp_vec()); end
    endtask

    task automatic test_stuck();
        for (int e = 1; e <= 9; e++) begin
            drive(C_G, 1'b0);
            if (e >= 7) begin
                checks++; if (stuck_err !== (HOLD_EN && e >= 8)) begin errors++; $display("FAIL stuck_edge%0d: got %b expected %b", e, stuck_err, HOLD_EN && e >= 8); end
            end
        end
        drive(C_G, 1'b1);
        checks++; if (stuck_err !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %b expected 0", stuck_err); end
        drive(C_G, 1'b0);
        checks++; if (dut_vec !== exp_vec() || stuck_err !== 1'b0) begin errors++; $display("FAIL stuck_no_repulse: got %b expected %b", dut_vec, exp_vec()); end
    endtask

    task automatic test_same_edge_clear();
        drive(C_Y, 1'b0);
        drive(C_G, 1'b1);
        checks++; if (order_err !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL set_wins: got ord=%b phase=%0d expected ord=1 phase=2", order_err, phase); end
        drive(C_Y, 1'b1);
        checks++; if (dut_vec !== exp_vec() || err_any !== 1'b0) begin errors++; $display("FAIL set_wins_clear: got %b expected %b", dut_vec, exp_vec()); end
    endtask

    task automatic test_wrap_and_async_reset();
        int start;
        start = m_cyc;
        for (int n = 0; n < (1 << CNT_W); n++) begin
            drive(C_R, 1'b0);
            drive(C_G, 1'b0);
            drive(C_Y, 1'b0);
        end
        checks++; if (cycle_cnt !== CNT_W'(start)) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", cycle_cnt, start); end
        drive(C_R, 1'b0);
        drive(C_G, 1'b0);
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL pre_reset: got %b expected %b", dut_vec, exp_vec()); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (dut_vec !== '0) begin errors++; $display("FAIL async_reset: got %b expected %b", dut_vec, {VW{1'b0}}); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(C_G, 1'b0);
        checks++; if (phase !== 2'd2 || locked !== 1'b1 || order_err !== 1'b0) begin errors++; $display("FAIL post_reset_lock: got phase=%0d locked=%b ord=%b expected 2 1 0", phase, locked, order_err); end
    endtask

    task automatic test_random();
        logic [2:0] l;
        bit         clr;
        int         r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      l = code_of(m_phase == 0 ? $urandom_range(1, 3) : (m_phase % 3) + 1);
            else if (r < 75) l = (m_phase == 0) ? code_of($urandom_range(1, 3)) : code_of(m_phase);
            else if (r < 88) l = code_of($urandom_range(1, 3));
            else             l = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 9) == 0);
            drive(l, clr);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rand_step%0d: light=%b clr=%b got %b expected %b", i, l, clr, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_cycles();
        test_order();
        test_code();
        test_stuck();
        test_same_edge_clear();
        test_wrap_and_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lamp_seq_monitor.md
Name: lamp_seq_monitor

Overview:
- Receiving end of the cyclic lamp interface.
- Watches the 3-bit one-hot RGY lamp bus and tracks the current phase.
- Checks that codes are legal and follow the RED->GREEN->YELLOW->RED order.
- Counts completed cycles and raises sticky error flags for illegal codes, out-of-order phases and stuck lamps; used as a bus checker next to any lamp sequencer.

Parameters:
- CNT_W, 8, width of the completed-cycle counter.
- MAX_HOLD, 8, number of consecutive edges one legal colour may persist before it counts as stuck; legal range 2..255.
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clock  input  1  rising-edge clock, same clock as the lamp sequencer.
- reset_n  input  1  asynchronous, active-low reset.
- light  input  [0:2]  lamp bus, bit0=R, bit1=G, bit2=Y; RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
- clear_err  input  1  synchronous clear of the sticky error flags.
- phase  output  2  tracked phase: 0=UNSYNC, 1=RED, 2=GREEN, 3=YELLOW.
- locked  output  1  high when phase != UNSYNC.
- cycle_cnt  output  CNT_W  completed YELLOW->RED transitions; wraps modulo 2^CNT_W.
- code_err  output  1  sticky: a non-one-hot code (including 3'b000) was seen.
- order_err  output  1  sticky: a legal colour arrived out of sequence.
- stuck_err  output  1  sticky: a colour was held for MAX_HOLD or more edges.
- err_any  output  1  combinational OR of the three error flags.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - phase=UNSYNC, cycle_cnt=0, hold_cnt=0.
  - code_err=0, order_err=0, stuck_err=0.
- Sampling: light is sampled at every rising edge. All outputs are registered and reflect that sample after the same edge (1-edge latency); err_any follows the registered flags combinationally.
- UNSYNC:
  - Legal code: phase jumps to that colour, hold_cnt=1, no error flagged.
  - Illegal code: stay in UNSYNC and set code_err.
- Locked state X, with next(RED)=GREEN, next(GREEN)=YELLOW, next(YELLOW)=RED:
  - light==X: stay, hold_cnt increments and saturates at MAX_HOLD.
  - light==next(X): advance, hold_cnt=1. If X==YELLOW, cycle_cnt also increments.
  - Legal code that is neither X nor next(X): set order_err, resync phase to the observed colour, hold_cnt=1, cycle_cnt unchanged.
  - Illegal code: set code_err, phase=UNSYNC, hold_cnt=0.
- Stuck check: stuck_err is set on the edge where hold_cnt goes from MAX_HOLD-1 to MAX_HOLD. It is set once per run and stays set while the run continues.
- Flags are sticky until clear_err is sampled high. If a new error occurs on the same edge as clear_err, that flag ends up 1 (set wins); flags without a new error clear to 0.
- clear_err does not affect phase, hold_cnt or cycle_cnt.
- Reset asserted mid-run: all state returns to the reset values above. The first legal code after reset deassertion locks the monitor without raising order_err.

Optional Feature:
- Macro: LAMP_SEQ_MONITOR_HOLD_CHECK_EN.
- Defined: stuck detection as described above; hold_cnt and the stuck sub-module are instantiated.
- Undefined: no hold counter, stuck_err is tied to 0, MAX_HOLD and HOLD_W are ignored. All other behaviour is identical.

Decomposition:
- Shared package lamp_pkg:
  - localparams RED, GREEN, YELLOW (3-bit codes).
  - 2-bit phase encodings PH_UNSYNC, PH_RED, PH_GREEN, PH_YELLOW.
  - a function mapping a legal code to its phase and a next-phase function.
  - The existing lamp sequencer migrates to the same colour constants.
- One sub-module, lamp_hold_timer (instantiated only under LAMP_SEQ_MONITOR_HOLD_CHECK_EN):
  - inputs: clock, reset_n, restart, hold.
  - behaviour: saturating HOLD_W counter; emits a one-edge stuck pulse at MAX_HOLD.
  - the top level holds the sticky flag.

Test Plan:
- Reset, then drive RED,GREEN,YELLOW repeated for 4 full cycles, one colour per edge -> phase steps 1,2,3,1...; cycle_cnt=4; err_any stays 0; locked=1 from the first sampled RED.
- Locked in GREEN, drive RED -> order_err=1 after that edge, phase=1, cycle_cnt unchanged. Then pulse clear_err with legal traffic -> order_err=0.
- Drive 3'b110, then 3'b000 -> code_err=1, phase=0, locked=0. Next YELLOW -> phase=3, no new order_err.
- With HOLD_CHECK_EN defined and MAX_HOLD=8, hold GREEN for 8 edges -> stuck_err rises exactly on edge 8, not edge 7. Undefined -> stuck_err stays 0.
- Error and clear_err on the same edge (YELLOW->GREEN with clear_err=1) -> order_err remains 1.
- With CNT_W=2, run 5 cycles -> cycle_cnt=1 (wrap). Assert reset_n low mid-GREEN, asynchronously -> all outputs return to reset values before the next edge.
